// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and the wrapped round-robin increment.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

   // An explicit compare against n-1 keeps non-power-of-two requester counts legal.
   function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
      return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// rr_pick: combinational rotate-priority search for the first request at or above ptr, with wrap.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            vld,
   output logic [ID_W-1:0] idx
);

   logic [2*NREQ-1:0] rot;
   logic [31:0]       sum;

   // Doubling the vector lets bit k of the shifted copy be request (ptr+k) wrapped.
   assign rot = {req, req} >> ptr;

   always_comb begin
      vld = 1'b0;
      idx = '0;
      sum = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = 32'(ptr) + 32'(k);
            vld = 1'b1;
            idx = ID_W'((sum >= 32'(NREQ)) ? sum - 32'(NREQ) : sum);
         end
      end
   end

endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: packet-aware round-robin arbiter sharing one FIFO push port, tagging words with their source.
module fifo_push_arb
   import fifo_arb_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int DATA_W = 32,
   localparam int ID_W   = $clog2(NREQ)
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NREQ-1:0]                req_vld,
   input  logic [NREQ-1:0][DATA_W-1:0]    req_dat,
   input  logic [NREQ-1:0]                req_last,
   output logic [NREQ-1:0]                req_rdy,
   output logic                           fifo_we,
   output logic [ID_W+DATA_W-1:0]         fifo_wd,
   input  logic                           fifo_full,
   input  logic                           arb_fsh,
   output logic [NREQ-1:0]                arb_gnt,
   output logic                           arb_busy
);

   arb_state_e      state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic            pick_vld;
   logic [ID_W-1:0] pick_idx;
   logic            act;
   logic            acc;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_vld),
      .ptr (rr_ptr_q),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   // A flush silences every output in the cycle it is asserted.
   assign act      = (state_q == ARB_BUSY) & ~arb_fsh;
   assign acc      = act & req_vld[gnt_id_q] & ~fifo_full;
   assign arb_busy = act;
   assign arb_gnt  = act ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id_q) : '0;
   assign req_rdy  = fifo_full ? '0 : arb_gnt;
   assign fifo_we  = acc;
   assign fifo_wd  = act ? {gnt_id_q, req_dat[gnt_id_q]} : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      if (arb_fsh) begin
         state_d  = ARB_IDLE;
         rr_ptr_d = '0;
         gnt_id_d = '0;
      end else if (state_q == ARB_IDLE && pick_vld) begin
         state_d  = ARB_BUSY;
         gnt_id_d = pick_idx;
      end else if (acc && req_last[gnt_id_q]) begin
         state_d  = ARB_IDLE;
         rr_ptr_d = ID_W'(wrap_inc(32'(gnt_id_q), 32'(NREQ)));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         gnt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
      end
   end

endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin, packet-aware arbiter sharing the push port of one `sync_fifo` between NREQ requesters. Each requester sends multi-beat packets over a valid/ready handshake. Once granted, a requester holds the FIFO until its last beat is accepted. Every pushed word is tagged with its source index so the pop side can demultiplex.

## Interface
- NREQ, 4, number of requesters (2..16, need not be a power of two)
- DATA_W, 32, payload width per beat
- ID_W, $clog2(NREQ), source-tag width; do not override
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous assert, active-low
- req_vld  input  NREQ  per-requester beat valid
- req_dat  input  NREQ x DATA_W  per-requester beat data (packed, index i at [i])
- req_last  input  NREQ  per-requester last-beat marker, qualified by req_vld
- req_rdy  output  NREQ  per-requester beat accept
- fifo_we  output  1  to FIFO push
- fifo_wd  output  ID_W+DATA_W  {source id, data}
- fifo_full  input  1  from FIFO
- arb_fsh  input  1  synchronous flush of arbiter state, asserted together with FIFO flush
- arb_gnt  output  NREQ  one-hot current grant, all-zero when idle
- arb_busy  output  1  a packet is in progress

## Operation
- FSM states:
  - ARB_IDLE: no owner.
  - ARB_BUSY: owner register `gnt_id` valid.
- ARB_IDLE behaviour:
  - If any req_vld is set, pick the first set bit searching upward from `rr_ptr` with wrap (index NREQ-1 wraps to 0).
  - Load `gnt_id` with the pick and go to ARB_BUSY.
  - Outputs stay inactive this cycle (req_rdy=0, fifo_we=0).
- ARB_BUSY behaviour:
  - Beat accept: `acc = req_vld[gnt_id] & ~fifo_full`.
  - req_rdy[gnt_id] = ~fifo_full; all other req_rdy are 0.
  - fifo_we = acc; fifo_wd = {gnt_id, req_dat[gnt_id]}.
- Packet end: on acc & req_last[gnt_id]:
  - Return to ARB_IDLE.
  - rr_ptr <= (gnt_id==NREQ-1) ? 0 : gnt_id+1.
- Owner hold: while busy, req_vld dropping on the owner does not release the grant; the FSM waits indefinitely.
- FIFO overflow: fifo_we is never asserted while fifo_full=1, so the FIFO can never overflow through this block.
- arb_busy = (state==ARB_BUSY). arb_gnt = one-hot of gnt_id when busy, else 0.
- arb_fsh:
  - State goes to ARB_IDLE, rr_ptr to 0, gnt_id to 0.
  - Outputs are forced inactive in the same cycle.
  - Flush has priority over every other event, including an accept in the same cycle.
- Single-beat packet (req_vld & req_last on the first beat) is legal: BUSY lasts exactly one cycle when the FIFO is not full.
- Width rules:
  - rr_ptr and gnt_id are ID_W bits.
  - Wrap uses an explicit compare against NREQ-1, never modular overflow, so non-power-of-two NREQ is supported.

## Timing
- Reset values: state ARB_IDLE, rr_ptr 0, gnt_id 0. Outputs req_rdy 0, fifo_we 0, fifo_wd 0 (because gnt_id=0 and outputs are gated by the state), arb_gnt 0, arb_busy 0.
- Latency: first beat is pushed no earlier than 1 cycle after req_vld rises in IDLE (arbitration cycle).
- Throughput:
  - 1 beat/cycle within a packet when FIFO not full.
  - Between packets there is exactly 1 idle arbitration cycle.
- req_rdy, fifo_we and fifo_wd are combinational from req_vld/req_dat/fifo_full and registered state; there are no combinational paths from req_rdy back to req_vld.
- Reset mid-packet: immediate return to reset values. The requester must treat an unaccepted beat as dropped.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_e` enum {ARB_IDLE, ARB_BUSY}.
  - Helper function for the wrapped increment.
- Sub-module `rr_pick`:
  - Parameter NREQ.
  - Inputs req (NREQ) and ptr (ID_W).
  - Outputs vld and idx (ID_W).
  - Purely combinational rotate-priority search.
- Top holds the FSM, rr_ptr/gnt_id registers and output muxing. It is intended to sit directly in front of `sync_fifo` with FIFO_W = ID_W+DATA_W.

## Test plan
- Reset then req_vld=4'b0101, both sending 3-beat packets, FIFO never full:
  - Req 0 granted first, 3 words {0,data} pushed on consecutive cycles.
  - 1 idle cycle, then req 2's 3 words.
  - rr_ptr ends at 3.
- All four requesting continuously with 1-beat packets: grant order 0,1,2,3,0,…; fifo_we duty 50%.
- fifo_full asserted for 4 cycles mid-packet of req 1: fifo_we=0 and req_rdy=0 for those cycles, no beat lost or duplicated, packet completes in order.
- NREQ=3, requesters 2 then 0 active: after req 2 finishes, rr_ptr wraps to 0, and req 0 is granted.
- Flush:
  - arb_fsh pulsed during beat 2 of a 5-beat packet: next cycle arb_busy=0, arb_gnt=0, rr_ptr=0.
  - A beat presented in the flush cycle is not pushed.
- rstn asserted low mid-packet asynchronously: all outputs 0 immediately; after release, arbitration restarts from index 0.
